// File: rtl/fft_output_sequencer.sv
// fft_output_sequencer
//
// Streams a completed N-point in-place FFT result out of two half-size
// memory banks as samples k = 0..N-1 on a valid/ready interface.
// For each k the memory index is m = bitrev(k), or m = k in natural
// order. The bank is the parity of m and the bank address is m[R-2:0].
// Reads are pipelined against a fixed RAM latency. A credit scheme
// bounds the reads so the small output FIFO can never overflow.
//
// Optional feature (macro FFT_OUT_INDEX_EN):
//   When defined, adds o_tx_index, the sample index k of the FIFO head.
//   The index is carried through the read pipe and FIFO with the data.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   start pulse, honoured only in idle
//   i_abort                   synchronous flush back to idle
//   i_natural                 order select, latched at start
//   o_busy, o_done            frame in progress / one-cycle completion pulse
//   o_m0_*, i_m0_rdata        bank0 read port
//   o_m1_*, i_m1_rdata        bank1 read port
//   o_tx_data/valid/last      output stream; i_tx_ready is downstream accept
//   o_tx_index                (FFT_OUT_INDEX_EN only) sample index k
module fft_output_sequencer #(
  parameter int N      = 32,
  parameter int R      = 5,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_natural,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_m0_r_en,
  output logic [R-2:0]  o_m0_addr,
  input  logic [DW-1:0] i_m0_rdata,
  output logic          o_m1_r_en,
  output logic [R-2:0]  o_m1_addr,
  input  logic [DW-1:0] i_m1_rdata,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_tx_last
`ifdef FFT_OUT_INDEX_EN
  ,
  output logic [R-1:0]  o_tx_index
`endif
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [R-1:0] LAST_IDX = R'(N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e         state_q, state_d;
  logic           natural_q, natural_d;
  logic [R-1:0]   iss_cnt_q, iss_cnt_d;
  logic [R-1:0]   out_cnt_q, out_cnt_d;
  logic [R-2:0]   m0_addr_q, m1_addr_q;

  logic           pipe_vld_q  [RD_LAT];
  logic           pipe_bank_q [RD_LAT];
  logic [DW-1:0]  fifo_data_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

`ifdef FFT_OUT_INDEX_EN
  logic [R-1:0]   pipe_idx_q  [RD_LAT];
  logic [R-1:0]   fifo_idx_q  [DEPTH];
`endif

  logic [R-1:0]   mem_idx;
  logic           rd_bank;
  logic           issue;
  logic           credit_ok;
  int             inflight;
  logic           fifo_nempty;
  logic           pop;
  logic           push;
  logic [DW-1:0]  push_data;

  function automatic logic [R-1:0] bitrev(input logic [R-1:0] v);
    logic [R-1:0] r;
    for (int i = 0; i < R; i++) r[i] = v[R-1-i];
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_nempty = (count_q != '0);
  assign pop         = fifo_nempty && i_tx_ready;
  assign push        = pipe_vld_q[RD_LAT-1];
  assign push_data   = pipe_bank_q[RD_LAT-1] ? i_m1_rdata : i_m0_rdata;

  // Credit counts the sample leaving this cycle, so a full pipeline with
  // ready held high still issues one read per cycle.
  always_comb begin
    mem_idx  = natural_q ? iss_cnt_q : bitrev(iss_cnt_q);
    rd_bank  = ^mem_idx;
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(pipe_vld_q[i]);
    credit_ok = (int'(count_q) + inflight) < (DEPTH + int'(pop));
    issue     = (state_q == ST_RUN) && !i_abort && credit_ok;
  end

  always_comb begin
    state_d   = state_q;
    natural_d = natural_q;
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    if (pop && (out_cnt_q != LAST_IDX)) out_cnt_d = out_cnt_q + 1'b1;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d   = ST_RUN;
            natural_d = i_natural;
            iss_cnt_d = '0;
            out_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (iss_cnt_q == LAST_IDX) state_d = ST_DRAIN;
            else iss_cnt_d = iss_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop && (out_cnt_q == LAST_IDX)) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: FSM, counters, held addresses, pipe valids, FIFO pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      natural_q <= 1'b0;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      m0_addr_q <= '0;
      m1_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_vld_q[i] <= 1'b0;
    end else begin
      state_q   <= state_d;
      natural_q <= natural_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (o_m0_r_en) m0_addr_q <= mem_idx[R-2:0];
      if (o_m1_r_en) m1_addr_q <= mem_idx[R-2:0];
      if (i_abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        for (int i = 0; i < RD_LAT; i++) pipe_vld_q[i] <= 1'b0;
      end else begin
        pipe_vld_q[0] <= issue;
        for (int i = 1; i < RD_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_d;
      end
    end
  end

  // Data path: bank tags and FIFO storage are qualified by the valids above.
  always_ff @(posedge i_clk) begin
    pipe_bank_q[0] <= rd_bank;
    for (int i = 1; i < RD_LAT; i++) pipe_bank_q[i] <= pipe_bank_q[i-1];
    if (push) fifo_data_q[wr_ptr_q] <= push_data;
`ifdef FFT_OUT_INDEX_EN
    pipe_idx_q[0] <= iss_cnt_q;
    for (int i = 1; i < RD_LAT; i++) pipe_idx_q[i] <= pipe_idx_q[i-1];
    if (push) fifo_idx_q[wr_ptr_q] <= pipe_idx_q[RD_LAT-1];
`endif
  end

  assign o_busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done     = (state_q == ST_DONE);
  assign o_m0_r_en  = issue && !rd_bank;
  assign o_m1_r_en  = issue && rd_bank;
  // The idle bank's address holds its last issued value.
  assign o_m0_addr  = o_m0_r_en ? mem_idx[R-2:0] : m0_addr_q;
  assign o_m1_addr  = o_m1_r_en ? mem_idx[R-2:0] : m1_addr_q;
  assign o_tx_valid = fifo_nempty;
  // Data is gated so the stream reads zero whenever nothing is valid.
  assign o_tx_data  = fifo_nempty ? fifo_data_q[rd_ptr_q] : '0;
  assign o_tx_last  = fifo_nempty && (out_cnt_q == LAST_IDX);
`ifdef FFT_OUT_INDEX_EN
  assign o_tx_index = fifo_nempty ? fifo_idx_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_fft_output_sequencer.sv
module tb_fft_output_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, nat, rdy_a, rdy_b;

  // Instance a: RD_LAT=1, instance b: RD_LAT=3; shared control inputs.
  logic        a_busy, a_done, a_r0, a_r1, a_val, a_last;
  logic [3:0]  a_ad0, a_ad1;
  logic [31:0] a_rd0, a_rd1, a_dat;
  logic        b_busy, b_done, b_r0, b_r1, b_val, b_last;
  logic [3:0]  b_ad0, b_ad1;
  logic [31:0] b_rd0, b_rd1, b_dat;
  logic [4:0]  a_idx_s, b_idx_s;

`ifdef FFT_OUT_INDEX_EN
  logic [4:0] a_idx, b_idx;
  assign a_idx_s = a_idx;
  assign b_idx_s = b_idx;
`else
  assign a_idx_s = 5'd0;
  assign b_idx_s = 5'd0;
`endif

  fft_output_sequencer #(.N(32), .R(5), .DW(32), .RD_LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_natural(nat),
    .o_busy(a_busy), .o_done(a_done),
    .o_m0_r_en(a_r0), .o_m0_addr(a_ad0), .i_m0_rdata(a_rd0),
    .o_m1_r_en(a_r1), .o_m1_addr(a_ad1), .i_m1_rdata(a_rd1),
    .o_tx_data(a_dat), .o_tx_valid(a_val), .i_tx_ready(rdy_a), .o_tx_last(a_last)
`ifdef FFT_OUT_INDEX_EN
    , .o_tx_index(a_idx)
`endif
  );

  fft_output_sequencer #(.N(32), .R(5), .DW(32), .RD_LAT(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_natural(nat),
    .o_busy(b_busy), .o_done(b_done),
    .o_m0_r_en(b_r0), .o_m0_addr(b_ad0), .i_m0_rdata(b_rd0),
    .o_m1_r_en(b_r1), .o_m1_addr(b_ad1), .i_m1_rdata(b_rd1),
    .o_tx_data(b_dat), .o_tx_valid(b_val), .i_tx_ready(rdy_b), .o_tx_last(b_last)
`ifdef FFT_OUT_INDEX_EN
    , .o_tx_index(b_idx)
`endif
  );

  // Memory content: word for memory index m carries m in two fields.
  function automatic logic [31:0] word(input logic [4:0] m);
    return {16'hC0DE, 3'b000, m, 3'b000, ~m};
  endfunction

  function automatic logic [31:0] bank_word(input logic b, input logic [3:0] ad);
    return word({b ^ (^ad), ad});
  endfunction

  function automatic logic [4:0] brev5(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  // Bank models: latency 1 for a, 3 for b; no read gives a poison word.
  logic [31:0] pa0 [1], pa1 [1], pb0 [3], pb1 [3];
  always @(posedge clk) begin
    pa0[0] <= a_r0 ? bank_word(1'b0, a_ad0) : 32'hDEAD_BEEF;
    pa1[0] <= a_r1 ? bank_word(1'b1, a_ad1) : 32'hDEAD_BEEF;
    pb0[0] <= b_r0 ? bank_word(1'b0, b_ad0) : 32'hDEAD_BEEF;
    pb1[0] <= b_r1 ? bank_word(1'b1, b_ad1) : 32'hDEAD_BEEF;
    for (int i = 1; i < 3; i++) begin
      pb0[i] <= pb0[i-1];
      pb1[i] <= pb1[i-1];
    end
  end
  assign a_rd0 = pa0[0];
  assign a_rd1 = pa1[0];
  assign b_rd0 = pb0[2];
  assign b_rd1 = pb1[2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard queues: {index, last, data}.
  logic [37:0] qa[$], qb[$];
  logic [4:0]  rd_log_a[$];
  int acc_a, acc_b, iss_a, iss_b, max_a, max_b, outst_a, outst_b;
  int first_v_a, first_v_b, done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b;
  int t_start, da0, db0;
  int rmode;
  logic        st_a, st_b, st_last_a, st_last_b;
  logic [31:0] st_dat_a, st_dat_b;
  logic [3:0]  prev_a0, prev_a1;
  logic [37:0] exp_e;

  initial begin
    acc_a = 0; acc_b = 0; iss_a = 0; iss_b = 0; max_a = 0; max_b = 0;
    first_v_a = -1; first_v_b = -1; done_cnt_a = 0; done_cnt_b = 0;
    done_cyc_a = 0; done_cyc_b = 0;
  end

  // Monitor for instance a.
  always @(negedge clk) begin
    if (!rst_n) begin
      st_a = 1'b0; prev_a0 = 4'd0; prev_a1 = 4'd0;
    end else begin
      outst_a = iss_a - acc_a;
      if (outst_a > max_a) max_a = outst_a;
      if (a_r0 || a_r1) begin
        chk("a_bank_exclusive", 64'(a_r0 & a_r1), 64'd0);
        iss_a++;
        rd_log_a.push_back({a_r1, a_r1 ? a_ad1 : a_ad0});
      end
      if (!a_r0) chk("a_m0_addr_hold", 64'(a_ad0), 64'(prev_a0));
      if (!a_r1) chk("a_m1_addr_hold", 64'(a_ad1), 64'(prev_a1));
      if (st_a) chk("a_stall_stable", 64'({a_val, a_last, a_dat}), 64'({1'b1, st_last_a, st_dat_a}));
      if (a_val && rdy_a) begin
        chk("a_sample_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          exp_e = qa.pop_front();
          chk("a_sample", 64'({a_idx_s, a_last, a_dat}), 64'(exp_e));
        end
        acc_a++;
      end
      if (a_val && first_v_a < 0) first_v_a = cyc;
      if (a_done) begin done_cnt_a++; done_cyc_a = cyc; end
      st_a = a_val && !rdy_a && !abort;
      st_last_a = a_last; st_dat_a = a_dat;
      prev_a0 = a_ad0; prev_a1 = a_ad1;
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (!rst_n) begin
      st_b = 1'b0;
    end else begin
      outst_b = iss_b - acc_b;
      if (outst_b > max_b) max_b = outst_b;
      if (b_r0 || b_r1) begin
        chk("b_bank_exclusive", 64'(b_r0 & b_r1), 64'd0);
        iss_b++;
      end
      if (st_b) chk("b_stall_stable", 64'({b_val, b_last, b_dat}), 64'({1'b1, st_last_b, st_dat_b}));
      if (b_val && rdy_b) begin
        chk("b_sample_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          exp_e = qb.pop_front();
          chk("b_sample", 64'({b_idx_s, b_last, b_dat}), 64'(exp_e));
        end
        acc_b++;
      end
      if (b_val && first_v_b < 0) first_v_b = cyc;
      if (b_done) begin done_cnt_b++; done_cyc_b = cyc; end
      st_b = b_val && !rdy_b && !abort;
      st_last_b = b_last; st_dat_b = b_dat;
    end
  end

  function automatic logic [63:0] pack_a();
    return 64'({a_busy, a_done, a_r0, a_ad0, a_r1, a_ad1, a_val, a_last, a_dat, a_idx_s});
  endfunction

  function automatic logic [63:0] pack_b();
    return 64'({b_busy, b_done, b_r0, b_ad0, b_r1, b_ad1, b_val, b_last, b_dat, b_idx_s});
  endfunction

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    nat   = 1'($urandom_range(0, 1));
    rdy_a = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    rdy_b = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input logic natural);
    logic [4:0] m;
    start = 1'b1;
    nat   = natural;
    for (int k = 0; k < 32; k++) begin
      m = natural ? 5'(k) : brev5(5'(k));
`ifdef FFT_OUT_INDEX_EN
      qa.push_back({5'(k), k == 31, word(m)});
      qb.push_back({5'(k), k == 31, word(m)});
`else
      qa.push_back({5'd0, k == 31, word(m)});
      qb.push_back({5'd0, k == 31, word(m)});
`endif
    end
    acc_a = 0; acc_b = 0; iss_a = 0; iss_b = 0; max_a = 0; max_b = 0;
    first_v_a = -1; first_v_b = -1;
    rd_log_a.delete();
    da0 = done_cnt_a; db0 = done_cnt_b;
    t_start = cyc;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    step();
    while ((done_cnt_a == da0 || done_cnt_b == db0) && g < 400) begin
      step();
      g++;
    end
    chk("frame_completes", 64'(g < 400), 64'd1);
  endtask

  task automatic frame_checks(input logic timed);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    chk("a_fifo_bound", 64'(max_a <= 2), 64'd1);
    chk("b_fifo_bound", 64'(max_b <= 4), 64'd1);
    if (timed) begin
      chk("a_start_to_done", 64'(done_cyc_a - t_start), 64'd35);
      chk("b_start_to_done", 64'(done_cyc_b - t_start), 64'd37);
      chk("a_first_valid", 64'(first_v_a - t_start), 64'd3);
      chk("b_first_valid", 64'(first_v_b - t_start), 64'd5);
    end
  endtask

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; nat = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_outputs", pack_a(), 64'd0);
    chk("b_reset_outputs", pack_b(), 64'd0);
    rst_n = 1'b1;
    step(); step();

    // Bit-reversed frame, ready high.
    start_frame(1'b0);
    wait_done();
    frame_checks(1'b1);
    chk("a_rd_k0", 64'(rd_log_a[0]), 64'h00);
    chk("a_rd_k1", 64'(rd_log_a[1]), 64'h10);
    chk("a_rd_k3", 64'(rd_log_a[3]), 64'h08);
    chk("a_read_count", 64'(rd_log_a.size()), 64'd32);

    // Natural frame.
    start_frame(1'b1);
    wait_done();
    frame_checks(1'b1);
    chk("a_rd_nat_k5", 64'(rd_log_a[5]), 64'h05);
    chk("a_rd_nat_k7", 64'(rd_log_a[7]), 64'h17);

    // Random backpressure.
    rmode = 1;
    start_frame(1'b0);
    wait_done();
    frame_checks(1'b0);
    rmode = 0;

    // Abort at output sample 10, with a start in the same cycle.
    start_frame(1'b0);
    g = 0;
    step();
    while (acc_a != 10 && g < 100) begin
      step();
      g++;
    end
    chk("a_reach_sample10", 64'(acc_a), 64'd10);
    chk("a_sample10_valid", 64'(a_val), 64'd1);
    abort = 1'b1; start = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    step();
    chk("a_abort_ren", 64'({a_r0, a_r1}), 64'd0);
    chk("a_abort_valid", 64'(a_val), 64'd0);
    chk("a_abort_busy", 64'(a_busy), 64'd0);
    chk("b_abort_valid", 64'(b_val), 64'd0);
    chk("b_abort_ren", 64'({b_r0, b_r1}), 64'd0);
    qa.delete(); qb.delete();
    da0 = done_cnt_a; db0 = done_cnt_b;
    repeat (40) step();
    chk("a_no_done_after_abort", 64'(done_cnt_a), 64'(da0));
    chk("b_no_done_after_abort", 64'(done_cnt_b), 64'(db0));
    chk("a_start_with_abort_ignored", 64'(a_busy), 64'd0);

    // Clean frame after abort.
    start_frame(1'b1);
    wait_done();
    frame_checks(1'b1);

    // Start while busy is ignored: order and timing unchanged.
    start_frame(1'b0);
    repeat (5) step();
    start = 1'b1; nat = 1'b1;
    wait_done();
    frame_checks(1'b1);

    // Asynchronous reset mid-frame.
    start_frame(1'b1);
    repeat (12) step();
    chk("a_busy_before_reset", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_reset_outputs", pack_a(), 64'd0);
    chk("b_async_reset_outputs", pack_b(), 64'd0);
    qa.delete(); qb.delete();
    step(); step();
    rst_n = 1'b1;
    step();

    // Full frame after reset, random backpressure.
    rmode = 1;
    start_frame(1'b0);
    wait_done();
    frame_checks(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
